// File: rtl/lrwait_qnode_multi.sv
// Multi-slot LR/SC queue node: tracks LRwait reservations, passes traffic through combinationally and
// injects a wake-up LR the cycle after a slot reaches WakeUp; wake-ups and full-slot LRs stall the core.
module lrwait_qnode_multi #(
    parameter int NumSlots  = 2,
    parameter int MetaWidth = 16,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] snitch_qaddr_i,
    input  logic                 snitch_qwrite_i,
    input  logic [3:0]           snitch_qamo_i,
    input  logic [DataWidth-1:0] snitch_qdata_i,
    input  logic [DataWidth/8-1:0] snitch_qstrb_i,
    input  logic [IdWidth-1:0]   snitch_qid_i,
    input  logic                 snitch_qvalid_i,
    output logic                 snitch_qready_o,
    output logic [DataWidth-1:0] snitch_pdata_o,
    output logic                 snitch_perror_o,
    output logic [IdWidth-1:0]   snitch_pid_o,
    output logic                 snitch_pvalid_o,
    input  logic                 snitch_pready_i,
    output logic [AddrWidth-1:0] tile_qaddr_o,
    output logic                 tile_qwrite_o,
    output logic [3:0]           tile_qamo_o,
    output logic [DataWidth-1:0] tile_qdata_o,
    output logic [DataWidth/8-1:0] tile_qstrb_o,
    output logic [IdWidth-1:0]   tile_qid_o,
    output logic                 tile_qlrwait_o,
    output logic                 tile_qvalid_o,
    input  logic                 tile_qready_i,
    input  logic [DataWidth-1:0] tile_pdata_i,
    input  logic                 tile_perror_i,
    input  logic [IdWidth-1:0]   tile_pid_i,
    input  logic                 tile_plrwait_i,
    input  logic                 tile_pvalid_i,
    output logic                 tile_pready_o,
    output logic                 slots_full_o
);
    localparam logic [3:0] AmoLr = 4'hA;
    localparam logic [3:0] AmoSc = 4'hB;

    typedef enum logic [2:0] {
        S_FREE, S_WAIT_LR, S_READY_SC, S_SC_SENT, S_IN_LRQ, S_WAKEUP
    } slot_state_e;

    slot_state_e          state_q [NumSlots];
    slot_state_e          state_d [NumSlots];
    logic [AddrWidth-1:0] addr_q  [NumSlots];
    logic [AddrWidth-1:0] addr_d  [NumSlots];
    logic [IdWidth-1:0]   id_q    [NumSlots];
    logic [IdWidth-1:0]   id_d    [NumSlots];
    logic [IdWidth-1:0]   sc_id_q [NumSlots];
    logic [IdWidth-1:0]   sc_id_d [NumSlots];
    logic [MetaWidth-1:0] meta_q  [NumSlots];
    logic [MetaWidth-1:0] meta_d  [NumSlots];
    logic [NumSlots-1:0]  sc_seen_q, sc_seen_d;

    logic [NumSlots-1:0]  free_vec, alloc_oh, wake_oh, sc_oh, succ_oh, rsp_lr_oh, rsp_sc_oh;
    logic                 is_lr, is_sc, lr_stall, wake_any, wake_fire;
    logic                 q_acc, lr_acc, sc_acc, succ_vld, p_hs;
    logic [AddrWidth-1:0] wake_addr;
    logic [IdWidth-1:0]   wake_id;
    logic [DataWidth-1:0] wake_data;

    // Every slot lookup resolves to the lowest matching index, encoded one-hot.
    always_comb begin : select
        logic alloc_f, wake_f, sc_f, succ_f, rl_f, rs_f;
        alloc_f = 1'b0; wake_f = 1'b0; sc_f = 1'b0; succ_f = 1'b0; rl_f = 1'b0; rs_f = 1'b0;
        free_vec = '0; alloc_oh = '0; wake_oh = '0; sc_oh = '0; succ_oh = '0;
        rsp_lr_oh = '0; rsp_sc_oh = '0;
        for (int i = 0; i < NumSlots; i++) begin
            free_vec[i] = (state_q[i] == S_FREE);
            if (free_vec[i] && !alloc_f) begin
                alloc_oh[i] = 1'b1; alloc_f = 1'b1;
            end
            if (state_q[i] == S_WAKEUP && !wake_f) begin
                wake_oh[i] = 1'b1; wake_f = 1'b1;
            end
            if (!free_vec[i] && addr_q[i] == snitch_qaddr_i && !sc_seen_q[i] && !sc_f) begin
                sc_oh[i] = 1'b1; sc_f = 1'b1;
            end
            if (!free_vec[i] && id_q[i] == tile_pid_i && !succ_f) begin
                succ_oh[i] = 1'b1; succ_f = 1'b1;
            end
            if (state_q[i] == S_WAIT_LR && id_q[i] == tile_pid_i && !rl_f) begin
                rsp_lr_oh[i] = 1'b1; rl_f = 1'b1;
            end
            if (state_q[i] == S_SC_SENT && sc_id_q[i] == tile_pid_i && !rs_f) begin
                rsp_sc_oh[i] = 1'b1; rs_f = 1'b1;
            end
        end
    end

    always_comb begin : wake_mux
        wake_addr = '0;
        wake_id   = '0;
        wake_data = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (wake_oh[i]) begin
                wake_addr                 = addr_q[i];
                wake_id                   = id_q[i];
                wake_data[MetaWidth-1:0]  = meta_q[i];
            end
        end
    end

    assign is_lr     = (snitch_qamo_i == AmoLr);
    assign is_sc     = (snitch_qamo_i == AmoSc);
    assign lr_stall  = is_lr && !(|free_vec);
    assign wake_any  = |wake_oh;
    assign wake_fire = wake_any && tile_qready_i;
    assign slots_full_o = ~|free_vec;

    assign snitch_qready_o = !wake_any && !lr_stall && tile_qready_i;
    assign tile_qvalid_o   = wake_any || (snitch_qvalid_i && !lr_stall);
    assign tile_qaddr_o    = wake_any ? wake_addr : snitch_qaddr_i;
    assign tile_qwrite_o   = wake_any ? 1'b0      : snitch_qwrite_i;
    assign tile_qamo_o     = wake_any ? AmoLr     : snitch_qamo_i;
    assign tile_qdata_o    = wake_any ? wake_data : snitch_qdata_i;
    assign tile_qstrb_o    = wake_any ? '0        : snitch_qstrb_i;
    assign tile_qid_o      = wake_any ? wake_id   : snitch_qid_i;
    assign tile_qlrwait_o  = wake_any;

    // SuccUpdates terminate here; everything else is forwarded to the core.
    assign snitch_pdata_o  = tile_pdata_i;
    assign snitch_perror_o = tile_perror_i;
    assign snitch_pid_o    = tile_pid_i;
    assign snitch_pvalid_o = tile_pvalid_i && !tile_plrwait_i;
    assign tile_pready_o   = tile_plrwait_i || snitch_pready_i;

    assign q_acc    = snitch_qvalid_i && snitch_qready_o;
    assign lr_acc   = q_acc && is_lr;
    assign sc_acc   = q_acc && is_sc;
    assign succ_vld = tile_pvalid_i && tile_plrwait_i;
    assign p_hs     = snitch_pvalid_o && snitch_pready_i;

    // SuccUpdate is applied before the SC so a same-cycle pair lands directly in WakeUp.
    always_comb begin : next_state
        for (int i = 0; i < NumSlots; i++) begin
            state_d[i]   = state_q[i];
            addr_d[i]    = addr_q[i];
            id_d[i]      = id_q[i];
            sc_id_d[i]   = sc_id_q[i];
            meta_d[i]    = meta_q[i];
            sc_seen_d[i] = sc_seen_q[i];
            if (lr_acc && alloc_oh[i]) begin
                state_d[i] = S_WAIT_LR;
                addr_d[i]  = snitch_qaddr_i;
                id_d[i]    = snitch_qid_i;
            end
            if (p_hs && rsp_lr_oh[i]) state_d[i] = S_READY_SC;
            if (p_hs && rsp_sc_oh[i]) state_d[i] = S_FREE;
            if (succ_vld && succ_oh[i]) begin
                meta_d[i] = tile_pdata_i[MetaWidth-1:0];
                case (state_d[i])
                    S_WAIT_LR, S_READY_SC: state_d[i] = S_IN_LRQ;
                    S_SC_SENT:             state_d[i] = S_WAKEUP;
                    default: ;
                endcase
            end
            if (sc_acc && sc_oh[i]) begin
                sc_id_d[i]   = snitch_qid_i;
                sc_seen_d[i] = 1'b1;
                case (state_d[i])
                    S_READY_SC: state_d[i] = S_SC_SENT;
                    S_IN_LRQ:   state_d[i] = S_WAKEUP;
                    default: ;
                endcase
            end
            if (wake_fire && wake_oh[i]) state_d[i] = S_FREE;
            if (state_d[i] == S_FREE) begin
                addr_d[i]    = '0;
                id_d[i]      = '0;
                sc_id_d[i]   = '0;
                meta_d[i]    = '0;
                sc_seen_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sc_seen_q <= '0;
            for (int i = 0; i < NumSlots; i++) begin
                state_q[i] <= S_FREE;
                addr_q[i]  <= '0;
                id_q[i]    <= '0;
                sc_id_q[i] <= '0;
                meta_q[i]  <= '0;
            end
        end else begin
            sc_seen_q <= sc_seen_d;
            for (int i = 0; i < NumSlots; i++) begin
                state_q[i] <= state_d[i];
                addr_q[i]  <= addr_d[i];
                id_q[i]    <= id_d[i];
                sc_id_q[i] <= sc_id_d[i];
                meta_q[i]  <= meta_d[i];
            end
        end
    end
endmodule

// File: tb/tb_lrwait_qnode_multi.sv
// Bench for lrwait_qnode_multi: directed LR/SC/SuccUpdate scenarios plus random traffic,
// checked by a queue scoreboard fed from a slot-level reference model.
module tb_lrwait_qnode_multi;
    localparam int NS = 2;
    localparam int M_FREE = 0, M_WAITLR = 1, M_READY = 2, M_SCSENT = 3, M_INLRQ = 4, M_WAKE = 5;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] snitch_qaddr_i, snitch_qdata_i, tile_pdata_i;
    logic        snitch_qwrite_i, snitch_qvalid_i, snitch_pready_i;
    logic [3:0]  snitch_qamo_i, snitch_qstrb_i, snitch_qid_i, tile_pid_i;
    logic        tile_qready_i, tile_perror_i, tile_plrwait_i, tile_pvalid_i;
    logic        snitch_qready_o, snitch_perror_o, snitch_pvalid_o;
    logic [31:0] snitch_pdata_o, tile_qaddr_o, tile_qdata_o;
    logic [3:0]  snitch_pid_o, tile_qamo_o, tile_qstrb_o, tile_qid_o;
    logic        tile_qwrite_o, tile_qlrwait_o, tile_qvalid_o, tile_pready_o, slots_full_o;

    lrwait_qnode_multi #(.NumSlots(NS), .MetaWidth(16), .AddrWidth(32), .DataWidth(32), .IdWidth(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .snitch_qaddr_i(snitch_qaddr_i), .snitch_qwrite_i(snitch_qwrite_i), .snitch_qamo_i(snitch_qamo_i),
        .snitch_qdata_i(snitch_qdata_i), .snitch_qstrb_i(snitch_qstrb_i), .snitch_qid_i(snitch_qid_i),
        .snitch_qvalid_i(snitch_qvalid_i), .snitch_qready_o(snitch_qready_o),
        .snitch_pdata_o(snitch_pdata_o), .snitch_perror_o(snitch_perror_o), .snitch_pid_o(snitch_pid_o),
        .snitch_pvalid_o(snitch_pvalid_o), .snitch_pready_i(snitch_pready_i),
        .tile_qaddr_o(tile_qaddr_o), .tile_qwrite_o(tile_qwrite_o), .tile_qamo_o(tile_qamo_o),
        .tile_qdata_o(tile_qdata_o), .tile_qstrb_o(tile_qstrb_o), .tile_qid_o(tile_qid_o),
        .tile_qlrwait_o(tile_qlrwait_o), .tile_qvalid_o(tile_qvalid_o), .tile_qready_i(tile_qready_i),
        .tile_pdata_i(tile_pdata_i), .tile_perror_i(tile_perror_i), .tile_pid_i(tile_pid_i),
        .tile_plrwait_i(tile_plrwait_i), .tile_pvalid_i(tile_pvalid_i), .tile_pready_o(tile_pready_o),
        .slots_full_o(slots_full_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int st; logic [31:0] addr; logic [3:0] id; logic [3:0] sc_id; logic [15:0] meta; logic sc_seen; } slot_t;
    typedef struct { logic [31:0] addr; logic write; logic [3:0] amo; logic [31:0] data; logic [3:0] strb;
                     logic [3:0] id; logic lrwait; bit chk_strb; } tq_t;
    typedef struct { logic [31:0] data; logic err; logic [3:0] id; } sp_t;
    typedef struct { logic full; logic qready; logic pready; } st_t;

    slot_t m [NS];
    tq_t   tq_q[$];
    sp_t   sp_q[$];
    st_t   st_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic slot_t clr();
        slot_t s;
        s.st = M_FREE; s.addr = '0; s.id = '0; s.sc_id = '0; s.meta = '0; s.sc_seen = 1'b0;
        return s;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) m[i] = clr();
    endfunction

    function automatic int first_st(int s);
        for (int i = 0; i < NS; i++) if (m[i].st == s) return i;
        return -1;
    endfunction

    function automatic bit lr_stall();
        return snitch_qamo_i == 4'hA && first_st(M_FREE) < 0;
    endfunction

    function automatic bit exp_qready();
        return first_st(M_WAKE) < 0 && !lr_stall() && tile_qready_i;
    endfunction

    // Apply one clock's worth of slot rules against the inputs present at the edge.
    function automatic void model_update();
        int al, scm, sm, rl, rs, w;
        bit acc, fire, succ, phs;
        acc  = snitch_qvalid_i && exp_qready();
        w    = first_st(M_WAKE);
        fire = (w >= 0) && tile_qready_i;
        succ = tile_pvalid_i && tile_plrwait_i;
        phs  = tile_pvalid_i && !tile_plrwait_i && snitch_pready_i;
        al = first_st(M_FREE); scm = -1; sm = -1; rl = -1; rs = -1;
        for (int i = 0; i < NS; i++) begin
            if (m[i].st != M_FREE) begin
                if (scm < 0 && m[i].addr == snitch_qaddr_i && !m[i].sc_seen) scm = i;
                if (sm < 0 && m[i].id == tile_pid_i) sm = i;
            end
            if (rl < 0 && m[i].st == M_WAITLR && m[i].id == tile_pid_i) rl = i;
            if (rs < 0 && m[i].st == M_SCSENT && m[i].sc_id == tile_pid_i) rs = i;
        end
        if (acc && snitch_qamo_i == 4'hA && al >= 0) begin
            m[al] = clr(); m[al].st = M_WAITLR; m[al].addr = snitch_qaddr_i; m[al].id = snitch_qid_i;
        end
        if (phs && rl >= 0) m[rl].st = M_READY;
        if (phs && rs >= 0) m[rs] = clr();
        if (succ && sm >= 0) begin
            m[sm].meta = tile_pdata_i[15:0];
            if (m[sm].st == M_WAITLR || m[sm].st == M_READY) m[sm].st = M_INLRQ;
            else if (m[sm].st == M_SCSENT) m[sm].st = M_WAKE;
        end
        if (acc && snitch_qamo_i == 4'hB && scm >= 0) begin
            m[scm].sc_id = snitch_qid_i; m[scm].sc_seen = 1'b1;
            if (m[scm].st == M_READY) m[scm].st = M_SCSENT;
            else if (m[scm].st == M_INLRQ) m[scm].st = M_WAKE;
        end
        if (fire) m[w] = clr();
    endfunction

    task automatic issue();
        tq_t t; sp_t p; st_t s; int w;
        #1;
        w = first_st(M_WAKE);
        if (w >= 0) begin
            t.addr = m[w].addr; t.write = 1'b0; t.amo = 4'hA; t.data = {16'h0, m[w].meta};
            t.strb = '0; t.id = m[w].id; t.lrwait = 1'b1; t.chk_strb = 1'b0;
            tq_q.push_back(t);
        end else if (snitch_qvalid_i && !lr_stall()) begin
            t.addr = snitch_qaddr_i; t.write = snitch_qwrite_i; t.amo = snitch_qamo_i; t.data = snitch_qdata_i;
            t.strb = snitch_qstrb_i; t.id = snitch_qid_i; t.lrwait = 1'b0; t.chk_strb = 1'b1;
            tq_q.push_back(t);
        end
        if (tile_pvalid_i && !tile_plrwait_i) begin
            p.data = tile_pdata_i; p.err = tile_perror_i; p.id = tile_pid_i;
            sp_q.push_back(p);
        end
        s.full = first_st(M_FREE) < 0; s.qready = exp_qready(); s.pready = tile_plrwait_i || snitch_pready_i;
        st_q.push_back(s);
    endtask

    task automatic advance();
        @(posedge clk_i);
        if (!rst_ni) model_reset(); else model_update();
        #1;
    endtask

    task automatic step();
        issue();
        advance();
    endtask

    task automatic idle();
        snitch_qvalid_i = 0; snitch_qamo_i = 0; snitch_qaddr_i = 0; snitch_qwrite_i = 0;
        snitch_qdata_i = 0; snitch_qstrb_i = 0; snitch_qid_i = 0;
        tile_pvalid_i = 0; tile_plrwait_i = 0; tile_pdata_i = 0; tile_perror_i = 0; tile_pid_i = 0;
        tile_qready_i = 1; snitch_pready_i = 1;
    endtask

    task automatic req(logic [3:0] amo, logic [31:0] addr, logic [3:0] id);
        snitch_qvalid_i = 1; snitch_qamo_i = amo; snitch_qaddr_i = addr; snitch_qid_i = id;
        snitch_qdata_i = $urandom; snitch_qstrb_i = 4'hF;
    endtask

    task automatic rsp(logic [3:0] id, logic lw, logic [31:0] data);
        tile_pvalid_i = 1; tile_pid_i = id; tile_plrwait_i = lw; tile_pdata_i = data;
    endtask

    task automatic do_reset();
        rst_ni = 0; model_reset(); idle();
        step(); step();
        rst_ni = 1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a request or response.
    initial begin
        tq_t t; sp_t p; st_t s;
        forever begin
            @(posedge clk_i); #3;
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                chk("slots_full", 32'(slots_full_o), 32'(s.full));
                chk("snitch_qready", 32'(snitch_qready_o), 32'(s.qready));
                chk("tile_pready", 32'(tile_pready_o), 32'(s.pready));
                if (tile_qvalid_o) begin
                    if (tq_q.size() == 0) chk("tile_qvalid_extra", 32'(tile_qvalid_o), 32'd0);
                    else begin
                        t = tq_q.pop_front();
                        chk("tile_qaddr", tile_qaddr_o, t.addr);
                        chk("tile_qwrite", 32'(tile_qwrite_o), 32'(t.write));
                        chk("tile_qamo", 32'(tile_qamo_o), 32'(t.amo));
                        chk("tile_qdata", tile_qdata_o, t.data);
                        chk("tile_qid", 32'(tile_qid_o), 32'(t.id));
                        chk("tile_qlrwait", 32'(tile_qlrwait_o), 32'(t.lrwait));
                        if (t.chk_strb) chk("tile_qstrb", 32'(tile_qstrb_o), 32'(t.strb));
                    end
                end else if (tq_q.size() > 0) begin
                    t = tq_q.pop_front();
                    chk("tile_qvalid_missing", 32'(tile_qvalid_o), 32'd1);
                end
                if (snitch_pvalid_o) begin
                    if (sp_q.size() == 0) chk("snitch_pvalid_extra", 32'(snitch_pvalid_o), 32'd0);
                    else begin
                        p = sp_q.pop_front();
                        chk("snitch_pdata", snitch_pdata_o, p.data);
                        chk("snitch_perror", 32'(snitch_perror_o), 32'(p.err));
                        chk("snitch_pid", 32'(snitch_pid_o), 32'(p.id));
                    end
                end else if (sp_q.size() > 0) begin
                    p = sp_q.pop_front();
                    chk("snitch_pvalid_missing", 32'(snitch_pvalid_o), 32'd1);
                end
            end
        end
    end

    initial begin
        rst_ni = 0; idle(); model_reset();
        @(posedge clk_i); #1;
        issue(); #2;
        chk("rst_full", 32'(slots_full_o), 32'd0);
        chk("rst_tqvalid", 32'(tile_qvalid_o), 32'd0);
        chk("rst_spvalid", 32'(snitch_pvalid_o), 32'd0);
        advance();
        rst_ni = 1;

        // LR/SC with no successor: no wake-up emitted
        req(4'hA, 32'h100, 4'd3); step();
        idle(); rsp(4'd3, 0, 32'h1234); step();
        idle(); req(4'hB, 32'h100, 4'd4); step();
        idle(); rsp(4'd4, 0, 32'h0); step();
        idle(); issue(); #2; chk("s34_no_wake", 32'(tile_qvalid_o), 32'd0); advance();

        // Successor recorded before SC: wake-up carries the metadata
        do_reset();
        req(4'hA, 32'h100, 4'd1); step();
        idle(); rsp(4'd1, 0, 32'h5); step();
        idle(); rsp(4'd1, 1, 32'h00AB); step();
        idle(); req(4'hB, 32'h100, 4'd2); step();
        idle(); req(4'h0, 32'h400, 4'd7); tile_qready_i = 0;
        issue(); #2;
        chk("s35_lrwait", 32'(tile_qlrwait_o), 32'd1);
        chk("s35_addr", tile_qaddr_o, 32'h100);
        chk("s35_data", tile_qdata_o, 32'h000000AB);
        chk("s35_amo", 32'(tile_qamo_o), 32'hA);
        chk("s35_qready", 32'(snitch_qready_o), 32'd0);
        advance();
        tile_qready_i = 1; issue(); #2;
        chk("s35_fire_valid", 32'(tile_qvalid_o), 32'd1);
        chk("s35_fire_qready", 32'(snitch_qready_o), 32'd0);
        advance();
        issue(); #2;
        chk("s35_after_lrwait", 32'(tile_qlrwait_o), 32'd0);
        chk("s35_after_qready", 32'(snitch_qready_o), 32'd1);
        advance();
        idle(); rsp(4'd2, 0, 32'h0); step();

        // Slot exhaustion and release
        do_reset();
        req(4'hA, 32'h100, 4'd5); step();
        req(4'hA, 32'h200, 4'd6); step();
        req(4'hA, 32'h300, 4'd7); issue(); #2;
        chk("s36_full", 32'(slots_full_o), 32'd1);
        chk("s36_stall_qready", 32'(snitch_qready_o), 32'd0);
        chk("s36_stall_tqvalid", 32'(tile_qvalid_o), 32'd0);
        advance();
        rsp(4'd6, 0, 32'h0); step();
        tile_pvalid_i = 0; req(4'hB, 32'h200, 4'd8); step();
        req(4'hA, 32'h300, 4'd7); rsp(4'd8, 0, 32'h0); step();
        tile_pvalid_i = 0; issue(); #2;
        chk("s36_release_full", 32'(slots_full_o), 32'd0);
        chk("s36_release_qready", 32'(snitch_qready_o), 32'd1);
        advance();
        idle(); issue(); #2; chk("s36_refull", 32'(slots_full_o), 32'd1); advance();

        // Two slots reach WakeUp together; lowest goes first and holds under backpressure
        do_reset();
        req(4'hA, 32'h100, 4'd1); step();
        req(4'hA, 32'h200, 4'd2); step();
        idle(); rsp(4'd1, 0, 32'h0); step();
        rsp(4'd2, 0, 32'h0); step();
        rsp(4'd1, 1, 32'h11); step();
        idle(); req(4'hB, 32'h200, 4'd4); step();
        req(4'hB, 32'h100, 4'd3); rsp(4'd2, 1, 32'h22); step();
        idle(); tile_qready_i = 0;
        for (int k = 0; k < 3; k++) begin
            issue(); #2;
            chk("s37_hold_addr", tile_qaddr_o, 32'h100);
            chk("s37_hold_id", 32'(tile_qid_o), 32'd1);
            advance();
        end
        tile_qready_i = 1; issue(); #2; chk("s37_first", tile_qaddr_o, 32'h100); advance();
        tile_qready_i = 0; issue(); #2;
        chk("s37_second_addr", tile_qaddr_o, 32'h200);
        chk("s37_second_data", tile_qdata_o, 32'h22);
        advance();
        tile_qready_i = 1; step();
        issue(); #2; chk("s37_done", 32'(tile_qvalid_o), 32'd0); advance();

        // SuccUpdate and SC together, then reset during the wake-up
        do_reset();
        req(4'hA, 32'h100, 4'd1); step();
        idle(); rsp(4'd1, 0, 32'h0); step();
        idle(); req(4'hB, 32'h100, 4'd2); rsp(4'd1, 1, 32'h55); step();
        idle(); tile_qready_i = 0; issue(); #2;
        chk("s38_wake", 32'(tile_qlrwait_o), 32'd1);
        chk("s38_data", tile_qdata_o, 32'h55);
        advance();
        rst_ni = 0; model_reset(); issue(); #2;
        chk("s38_rst_tqvalid", 32'(tile_qvalid_o), 32'd0);
        chk("s38_rst_full", 32'(slots_full_o), 32'd0);
        advance();
        rst_ni = 1; issue(); #2; chk("s38_no_survive", 32'(tile_qvalid_o), 32'd0); advance();
        rsp(4'd9, 1, 32'h77); issue(); #2;
        chk("orphan_pready", 32'(tile_pready_o), 32'd1);
        chk("orphan_spvalid", 32'(snitch_pvalid_o), 32'd0);
        advance();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            snitch_qvalid_i = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: snitch_qamo_i = 4'hA;
                1: snitch_qamo_i = 4'hB;
                2: snitch_qamo_i = 4'h0;
                default: snitch_qamo_i = 4'h5;
            endcase
            snitch_qaddr_i  = 32'($urandom_range(1, 3)) << 8;
            snitch_qid_i    = 4'($urandom_range(0, 3));
            snitch_qwrite_i = 1'($urandom_range(0, 1));
            snitch_qdata_i  = $urandom;
            snitch_qstrb_i  = 4'($urandom);
            tile_pvalid_i   = ($urandom_range(0, 9) < 4);
            tile_plrwait_i  = ($urandom_range(0, 9) < 3);
            tile_pid_i      = 4'($urandom_range(0, 3));
            tile_pdata_i    = $urandom;
            tile_perror_i   = 1'($urandom_range(0, 1));
            tile_qready_i   = ($urandom_range(0, 9) < 7);
            snitch_pready_i = ($urandom_range(0, 9) < 8);
            step();
        end

        idle(); step();
        @(posedge clk_i); #4;
        chk("tq_drain", 32'(tq_q.size()), 32'd0);
        chk("sp_drain", 32'(sp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lrwait_qnode_multi.md
LRWAIT_QNODE_MULTI -- requirements
Module: lrwait_qnode_multi

Interface
REQ-001 SHALL have parameter NumSlots, default 2: number of concurrently tracked LR reservations (1..8).
REQ-002 SHALL have parameter MetaWidth, default 16: successor-metadata width, at most DataWidth.
REQ-003 SHALL have parameter AddrWidth, default 32: address width.
REQ-004 SHALL have parameter DataWidth, default 32: data width.
REQ-005 SHALL have parameter IdWidth, default 4: request/response ID width.
REQ-006 SHALL have exactly one clock: clk_i, in, 1, rising-edge clock.
REQ-007 SHALL have rst_ni, in, 1: reset, asynchronous and active-low.
REQ-008 SHALL have snitch_q{addr,write,amo,data,strb,id,valid}_i, in, AddrWidth/1/4/DataWidth/DataWidth/8/IdWidth/1: core request; snitch_qready_o, out, 1.
REQ-009 SHALL have snitch_p{data,error,id,valid}_o, out, DataWidth/1/IdWidth/1: core response; snitch_pready_i, in, 1.
REQ-010 SHALL have tile_q{addr,write,amo,data,strb,id,lrwait,valid}_o, out, same widths plus lrwait 1: interconnect request; tile_qready_i, in, 1.
REQ-011 SHALL have tile_p{data,error,id,lrwait,valid}_i, in: interconnect response; tile_pready_o, out, 1.
REQ-012 SHALL have slots_full_o, out, 1: no free slot.

Function
REQ-013 SHALL keep per-slot state Free, WaitLR, ReadyForSC, ScSent, InLRQueue or WakeUp, plus addr, id, metadata and sc_seen.
REQ-014 An accepted LR (amo 4'hA, snitch_qvalid_i&&snitch_qready_o) SHALL allocate the lowest-index Free slot, storing addr and id, and move it to WaitLR.
REQ-015 When no slot is Free, an LR SHALL stall: snitch_qready_o=0 and tile_qvalid_o=0. Non-LR requests SHALL be unaffected.
REQ-016 A non-lrwait response with pid equal to the id of a WaitLR slot SHALL move that slot to ReadyForSC on its snitch handshake.
REQ-017 A response with tile_plrwait_i=1 (SuccUpdate) SHALL be absorbed: tile_pready_o=1, snitch_pvalid_o=0. Its tile_pdata_i[MetaWidth-1:0] SHALL be stored in the slot whose id equals tile_pid_i.
REQ-018 On a SuccUpdate, the matching slot SHALL transition WaitLR/ReadyForSC->InLRQueue and ScSent->WakeUp.
REQ-019 An accepted SC (amo 4'hB) SHALL match the lowest-index non-Free slot with equal addr and sc_seen=0, storing the SC id and setting sc_seen.
REQ-020 On an accepted SC, the matched slot SHALL transition ReadyForSC->ScSent and InLRQueue->WakeUp.
REQ-021 An unmatched SC SHALL pass through unchanged.
REQ-022 A non-lrwait response whose pid equals the SC id of a ScSent slot, on its snitch handshake, SHALL free that slot.
REQ-023 When any slot is in WakeUp, the block SHALL drive tile_qvalid_o=1, qamo=4'hA, qaddr=slot addr, qlrwait=1, qdata=zero-extended metadata, qid=slot id, qwrite=0.
REQ-024 During a wake-up, snitch_qready_o SHALL be 0; the lowest-index WakeUp slot goes first.
REQ-025 On tile_qready_i during a wake-up, that slot SHALL become Free; otherwise outputs SHALL hold stable.
REQ-026 A SuccUpdate and a matching SC in the same cycle SHALL take the slot directly to WakeUp.
REQ-027 A SuccUpdate for an id with no non-Free slot SHALL be absorbed and ignored.
REQ-028 Non-wake-up traffic SHALL be combinational pass-through with zero added latency.
REQ-029 A wake-up SHALL be issued no earlier than the cycle after entering WakeUp.
REQ-030 slots_full_o SHALL be registered-state-derived, not combinational from inputs.

Reset
REQ-031 On rst_ni low, all slots SHALL become Free with fields zeroed, regardless of current state, including mid wake-up.
REQ-032 In reset, tile_qvalid_o and snitch_pvalid_o SHALL follow pass-through, i.e. 0 when the inputs are 0.
REQ-033 slots_full_o SHALL be 0 in reset, and no pending wake-up SHALL survive reset.

Verification
REQ-034 LR addr 0x100 id 3 -> response id 3 -> SC 0x100 id 4 -> response id 4: slot0 Free again, no lrwait request emitted.
REQ-035 LR 0x100 id 1 -> response -> SuccUpdate id 1, data 0x00AB -> SC 0x100 id 2: next cycle lrwait request addr 0x100, data 0x000000AB, snitch_qready_o=0 until tile_qready_i.
REQ-036 With NumSlots=2: LRs 0x100 and 0x200 accepted, a third LR stalls with slots_full_o=1; freeing slot1 releases it into slot1.
REQ-037 Two slots reach WakeUp in the same cycle: slot0's wake-up is issued first, then slot1's, with tile_qready_i held low 3 cycles to check stability.
REQ-038 SuccUpdate arriving in the same cycle as a matching SC: WakeUp entered directly. Reset asserted mid wake-up: tile_qvalid_o drops and all slots are Free.
